ctu_scan_seq_ctl: RTL
=====================

# ctu_scan_seq_ctl

Sequencer for on-chip scan and macrotest. It sits directly upstream of each cluster's test stub and drives that stub's control inputs: pre-global-reset, shift enable, scan mode, macrotest, short-chain select and pin-based-scan. It runs a configured number of load/capture patterns and compresses the returning cluster scan-out bits (so_0..so_2) into a MISR signature for comparison by software/JTAG.

## Interface
Parameters:
- CNT_W, 16, width of shift-length and pattern counters
- MISR_W, 16, signature width (≥4)
- MISR_POLY, 16'h100B, feedback taps (x^16+x^12+x^3+x+1)
- RST_CYC, 8, cycles ctu_tst_pre_grst_l held low at test entry (≥1)
- SETTLE_CYC, 4, cycles between reset release and first shift (≥1)

Ports (clock and reset first):
- clk  in  1  block clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; ignored while busy
- abort  in  1  return to IDLE immediately
- cfg_macrotest  in  1  1 = macrotest, 0 = scan test
- cfg_short_chain  in  1  request short-chain configuration
- cfg_pin_based  in  1  pin-based scan (drives ctu_tst_scan_disable)
- cfg_shift_len  in  CNT_W  shift cycles per load
- cfg_num_pat  in  CNT_W  number of patterns
- cfg_cap_cyc  in  4  capture cycles per pattern (macrotest); scan test always uses 1
- so_0, so_1, so_2  in  1 each  cluster scan-outs from test stub
- ctu_tst_pre_grst_l  out  1  pre-global-reset, active low
- global_shift_enable  out  1  scan shift enable
- ctu_tst_scanmode  out  1  test mode active
- ctu_tst_macrotest  out  1  macrotest active
- ctu_tst_short_chain  out  1  short chain select
- ctu_tst_scan_disable  out  1  pin-based scan
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky config error, cleared on next accepted start
- misr  out  MISR_W  signature, held until next accepted start

## Operation
- States: IDLE, RESET, SETTLE, SHIFT, CAPTURE, DONE.
- IDLE: on start, latch all cfg_*, clear misr and err. If cfg_shift_len==0, cfg_num_pat==0, or (cfg_macrotest and cfg_cap_cyc==0), set err and go to DONE. Otherwise go to RESET.
- RESET: ctu_tst_pre_grst_l=0 for RST_CYC cycles, then SETTLE.
- SETTLE: SETTLE_CYC cycles, then SHIFT.
- SHIFT: global_shift_enable=1 for shift_len cycles. Then, if loads done < num_pat, go to CAPTURE; else go to DONE.
- CAPTURE: global_shift_enable=0 for cap_cyc cycles (macrotest) or 1 cycle (scan). Increments the pattern count, then SHIFT.
- Total shifts = num_pat+1. The first shift is load-only. Each later shift unloads the previous capture.
- MISR update on every SHIFT cycle except the first shift pass: misr ← {misr[W-2:0],0} ^ (misr[W-1] ? MISR_POLY : 0) ^ {0…,so_2,so_1,so_0}.
- ctu_tst_scanmode, ctu_tst_macrotest, ctu_tst_short_chain and ctu_tst_scan_disable come from the latched cfg and are asserted in RESET through SHIFT/CAPTURE. They are 0 in IDLE and DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort (any state except IDLE): next cycle goes to IDLE with all test outputs at reset values. No done pulse; misr frozen; err unchanged.
- abort and start in the same cycle in IDLE: start accepted. abort has priority in all other states.

## Timing
- Reset values: ctu_tst_pre_grst_l=1, misr=0; every other output 0.
- All outputs are registered. start at edge T → busy=1 and pre_grst_l=0 from T+1.
- First global_shift_enable high at T+1+RST_CYC+SETTLE_CYC.
- busy deasserts in the same cycle done pulses.
- Counters compare against latched cfg; cfg changes mid-run have no effect.
- rst_n low mid-sequence → reset values on the next edge.

## Structure
- Shared package/header ctu_scan_pkg: state encoding, default MISR_POLY, RST_CYC, SETTLE_CYC.
- Sub-module scan_misr (parameterised W/POLY; ports: clk, rst_n, clr, en, din[2:0], sig).

## Test plan
- Scan test, shift_len=4, num_pat=2, RST_CYC=8, SETTLE_CYC=4 → pre_grst_l low 8 cycles; shift-enable pattern 4 high/1 low/4 high/1 low/4 high; done at T+28.
- Macrotest, cap_cyc=3 → ctu_tst_macrotest=1 throughout, capture gaps of 3 cycles.
- so_0 driven 1, so_1/so_2 driven 0; shift_len=4, num_pat=1 → misr matches the reference model (first 4 shifts ignored).
- cfg_shift_len=0 → err=1, done at T+2, shift enable never asserted.
- abort mid-SHIFT → next cycle all test outputs at reset values, busy=0, no done, misr frozen.
- start while busy → ignored; rst_n low during CAPTURE → reset values next edge.

Source files
------------

// File: rtl/ctu_scan_pkg.sv
// Shared definitions for the CTU scan/macrotest sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding, the default MISR feedback polynomial
// and the default reset/settle durations, plus the packed bundle of
// test-stub mode controls that travels from latched config to outputs.
package ctu_scan_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // x^16 + x^12 + x^3 + x + 1 (x^16 term implicit in the shift-out).
  localparam logic [15:0] DEF_MISR_POLY  = 16'h100B;
  localparam int          DEF_RST_CYC    = 8;
  localparam int          DEF_SETTLE_CYC = 4;

  // Test-stub mode controls, asserted together from RESET through CAPTURE.
  typedef struct packed {
    logic scanmode;
    logic macrotest;
    logic short_chain;
    logic scan_disable;
  } tst_mode_t;

  localparam tst_mode_t TST_MODE_OFF = '0;

endpackage

// File: rtl/scan_misr.sv
// Multiple-input signature register folding 3 scan-out bits per cycle.
// Latency: signature reflects din one cycle after en is sampled high.
// Backpressure: none; updates on every enabled cycle.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (signature -> 0)
//   clr        : synchronous clear, takes priority over en
//   en         : fold din into the signature this cycle
//   din[2:0]   : {so_2, so_1, so_0}
//   sig        : registered signature
module scan_misr
  import ctu_scan_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = W'(DEF_MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [2:0]   din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_d;
  logic [W-1:0] sig_q;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      // Galois-style step: shift left, fold MSB back through taps, xor inputs.
      sig_d = {sig_q[W-2:0], 1'b0}
            ^ (sig_q[W-1] ? POLY : '0)
            ^ {{(W-3){1'b0}}, din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/ctu_scan_seq_ctl.sv
// Scan/macrotest sequencer driving a cluster test stub; compresses scan-out into a MISR.
// Latency: all outputs registered; busy/pre_grst_l change the cycle after start is sampled.
// Backpressure: none; start is ignored while busy, abort returns to idle next cycle.
//
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   start, abort             : one-cycle run request / immediate return to idle
//   cfg_*                    : run configuration, latched when start is accepted
//   so_0..so_2               : cluster scan-outs folded into the signature
//   ctu_tst_*, global_shift_enable : test-stub controls
//   busy, done, err, misr    : status, completion pulse, sticky config error, signature
module ctu_scan_seq_ctl
  import ctu_scan_pkg::*;
#(
  parameter int                CNT_W      = 16,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEF_MISR_POLY),
  parameter int                RST_CYC    = DEF_RST_CYC,
  parameter int                SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_macrotest,
  input  logic              cfg_short_chain,
  input  logic              cfg_pin_based,
  input  logic [CNT_W-1:0]  cfg_shift_len,
  input  logic [CNT_W-1:0]  cfg_num_pat,
  input  logic [3:0]        cfg_cap_cyc,
  input  logic              so_0,
  input  logic              so_1,
  input  logic              so_2,
  output logic              ctu_tst_pre_grst_l,
  output logic              global_shift_enable,
  output logic              ctu_tst_scanmode,
  output logic              ctu_tst_macrotest,
  output logic              ctu_tst_short_chain,
  output logic              ctu_tst_scan_disable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MISR_W-1:0] misr
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Sequencer state and counters.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;   // cycles spent in the current state
  logic [CNT_W-1:0] pat_q, pat_d;   // captures completed (= loads done)

  // Latched configuration.
  logic [CNT_W-1:0] shift_len_q, shift_len_d;
  logic [CNT_W-1:0] num_pat_q, num_pat_d;
  logic [3:0]       cap_len_q, cap_len_d;   // effective capture length (1 in scan test)
  tst_mode_t        mode_q, mode_d;

  // Registered outputs.
  logic             grst_l_q, grst_l_d;
  logic             gse_q, gse_d;
  tst_mode_t        tst_q, tst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Signature control.
  logic             misr_clr;
  logic             misr_en;

  logic             cfg_bad;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] shift_last;
  logic [CNT_W-1:0] cap_last;

  always_comb begin
    cfg_bad    = (cfg_shift_len == '0) || (cfg_num_pat == '0) ||
                 (cfg_macrotest && (cfg_cap_cyc == 4'd0));
    cnt_inc    = cnt_q + CNT_ONE;
    shift_last = shift_len_q - CNT_ONE;
    cap_last   = {{(CNT_W-4){1'b0}}, cap_len_q} - CNT_ONE;

    state_d     = state_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    shift_len_d = shift_len_q;
    num_pat_d   = num_pat_q;
    cap_len_d   = cap_len_q;
    mode_d      = mode_q;
    err_d       = err_q;
    misr_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort is deliberately not looked at here: a coincident start wins.
        if (start) begin
          shift_len_d = cfg_shift_len;
          num_pat_d   = cfg_num_pat;
          cap_len_d   = cfg_macrotest ? cfg_cap_cyc : 4'd1;
          mode_d      = '{scanmode:     1'b1,
                          macrotest:    cfg_macrotest,
                          short_chain:  cfg_short_chain,
                          scan_disable: cfg_pin_based};
          err_d       = cfg_bad;
          misr_clr    = 1'b1;
          cnt_d       = '0;
          pat_d       = '0;
          state_d     = cfg_bad ? ST_DONE : ST_RESET;
        end
      end
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == shift_last) begin
          cnt_d   = '0;
          // The pass after the last capture only unloads; then we are finished.
          state_d = (pat_q < num_pat_q) ? ST_CAPTURE : ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == cap_last) begin
          cnt_d   = '0;
          pat_d   = pat_q + CNT_ONE;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    // Outputs are decoded from the next state so they line up with it.
    busy_d   = (state_d != ST_IDLE);
    grst_l_d = (state_d != ST_RESET);
    gse_d    = (state_d == ST_SHIFT);
    tst_d    = (state_d inside {ST_RESET, ST_SETTLE, ST_SHIFT, ST_CAPTURE}) ? mode_d
                                                                          : TST_MODE_OFF;
    // The pulse lands in the cycle after DONE, i.e. as busy drops.
    done_d   = (state_q == ST_DONE) && !abort;

    // The first shift pass only loads; its scan-out is not meaningful.
    misr_en  = (state_q == ST_SHIFT) && (pat_q != '0) && !abort;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pat_q       <= '0;
      shift_len_q <= '0;
      num_pat_q   <= '0;
      cap_len_q   <= '0;
      mode_q      <= TST_MODE_OFF;
      grst_l_q    <= 1'b1;
      gse_q       <= 1'b0;
      tst_q       <= TST_MODE_OFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      shift_len_q <= shift_len_d;
      num_pat_q   <= num_pat_d;
      cap_len_q   <= cap_len_d;
      mode_q      <= mode_d;
      grst_l_q    <= grst_l_d;
      gse_q       <= gse_d;
      tst_q       <= tst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  scan_misr #(
    .W    (MISR_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   ({so_2, so_1, so_0}),
    .sig   (misr)
  );

  assign ctu_tst_pre_grst_l   = grst_l_q;
  assign global_shift_enable  = gse_q;
  assign ctu_tst_scanmode     = tst_q.scanmode;
  assign ctu_tst_macrotest    = tst_q.macrotest;
  assign ctu_tst_short_chain  = tst_q.short_chain;
  assign ctu_tst_scan_disable = tst_q.scan_disable;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign err                  = err_q;

endmodule
